// File: rtl/rvx_mem_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings,
// FSM state type and the misalignment rule.
package rvx_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load-data aligner: picks the addressed byte/halfword lane from the raw
// memory word and sign- or zero-extends it according to funct3.
module load_align
  import rvx_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_s};
      F3_H:    data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory requests, waits for load responses while
// stalling upstream, aligns load data and registers the MEM/WB outputs.
module mem_access_unit
  import rvx_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [REG_AW-1:0] RdM,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [3:0]        dmem_req_be,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rdata,
  output logic              StallM,
  output logic              MisalignM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W
);

  mem_state_e      state_r;
  logic            misalign_s;
  logic            memop_s;
  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] lane_wdata_s;
  logic [3:0]      lane_be_s;

  assign misalign_s = ValidM & (MemReadM | MemWriteM) & is_misaligned(Funct3M, ALUResultM[1:0]);
  assign memop_s    = ValidM & (MemReadM | MemWriteM) & ~misalign_s;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (dmem_rsp_rdata),
    .addr_lo (ALUResultM[1:0]),
    .funct3  (Funct3M),
    .data    (load_data_s)
  );

  // Store data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    case (Funct3M)
      F3_B: begin
        lane_wdata_s = XLEN'({4{WriteDataM[7:0]}});
        lane_be_s    = 4'b0001 << ALUResultM[1:0];
      end
      F3_H: begin
        lane_wdata_s = XLEN'({2{WriteDataM[15:0]}});
        lane_be_s    = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        lane_wdata_s = WriteDataM;
        lane_be_s    = 4'b1111;
      end
    endcase
  end

  // Request channel and stall; fields are zero whenever no request is presented.
  always_comb begin
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    dmem_req_be    = 4'b0000;
    StallM         = 1'b0;
    case (state_r)
      IDLE: begin
        if (memop_s) begin
          dmem_req_valid = 1'b1;
          dmem_req_we    = MemWriteM;
          dmem_req_addr  = {ALUResultM[XLEN-1:2], 2'b00};
          dmem_req_wdata = MemWriteM ? lane_wdata_s : '0;
          dmem_req_be    = MemWriteM ? lane_be_s : 4'b0000;
          StallM         = MemReadM | ~dmem_req_ready;
        end else begin
          dmem_req_valid = 1'b0;
          StallM         = 1'b0;
        end
      end
      WAIT_RSP: StallM = ~dmem_rsp_valid;
      default:  StallM = 1'b0;
    endcase
  end

  // FSM and MEM/WB register; bubbles clear valid/write-enable but keep data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      MisalignM  <= 1'b0;
    end else begin
      MisalignM <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ValidM && !StallM) begin
            ValidW     <= 1'b1;
            RegWriteW  <= RegWriteM & ~misalign_s;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            ReadDataW  <= '0;
            MisalignM  <= misalign_s;
          end else begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
          end
          if (memop_s && MemReadM && dmem_req_ready) begin
            state_r <= WAIT_RSP;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            ValidW     <= 1'b1;
            RegWriteW  <= RegWriteM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            ReadDataW  <= load_data_s;
            state_r    <= IDLE;
          end else begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            state_r   <= WAIT_RSP;
          end
        end
        default: begin
          ValidW    <= 1'b0;
          RegWriteW <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// corner sequences and randomized instructions against a behavioural model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ValidM, RegWriteM, MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        StallM, MisalignM, ValidW, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_alu = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- behavioural reference model ----
  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit model_mis(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    return (rd || wr) && ((a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    longint unsigned v;
    int unsigned sz;
    int unsigned bits;
    sz   = acc_size(f3);
    bits = 8 * sz;
    v    = {32'h0, rdata};
    v    = v >> (8 * (a % 4));
    v    = v % (64'd1 << bits);
    if (!f3[2] && sz < 4 && v >= (64'd1 << (bits - 1)))
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    int unsigned off;
    int unsigned be;
    sz  = acc_size(f3);
    off = ((a % 4) / sz) * sz;
    be  = ((32'd1 << sz) - 1) << off;
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned sz;
    sz = acc_size(f3);
    if (sz == 1) return (wd % 256) * 32'h01010101;
    if (sz == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  // Runs one instruction to completion and checks request, stall and W outputs.
  task automatic do_instr(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [4:0] rd_idx,
                          input bit regw, input int rdy_wait, input int rsp_wait,
                          input bit spurious,
                          output logic [31:0] cap_wdata, output logic [3:0] cap_be);
    bit mis, memop, is_load, done, stall_now;
    int stalls, exp_stalls;
    logic [31:0] pc4;
    mis     = model_mis(rd, wr, f3, addr);
    memop   = (rd || wr) && !mis;
    is_load = memop && rd;
    exp_stalls = !memop ? 0 : (is_load ? rdy_wait + rsp_wait : rdy_wait);
    pc4 = $urandom;
    ValidM = 1'b1; RegWriteM = regw; MemReadM = rd; MemWriteM = wr;
    Funct3M = f3; ALUResultM = addr; WriteDataM = wdata; PCPlus4M = pc4; RdM = rd_idx;
    cap_wdata = 32'h0; cap_be = 4'h0;
    done = 1'b0; stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      dmem_req_ready = (cyc >= rdy_wait);
      dmem_rsp_valid = is_load ? (cyc == rdy_wait + rsp_wait) : (spurious && cyc == 0);
      dmem_rsp_rdata = dmem_rsp_valid ? rdata : $urandom;
      #1;
      if (cyc == 0) chk("req_valid", {31'h0, dmem_req_valid}, {31'h0, memop});
      if (memop && cyc == rdy_wait) begin
        chk("req_addr", dmem_req_addr, {addr[31:2], 2'b00});
        chk("req_we", {31'h0, dmem_req_we}, {31'h0, wr});
        chk("req_be", {28'h0, dmem_req_be}, wr ? {28'h0, model_be(f3, addr)} : 32'h0);
        if (wr) chk("req_wdata", dmem_req_wdata, model_wdata(f3, wdata));
        cap_wdata = dmem_req_wdata; cap_be = dmem_req_be;
      end
      if (is_load && cyc > rdy_wait) chk("req_valid_wait", {31'h0, dmem_req_valid}, 32'h0);
      stall_now = StallM;
      tick();
      if (!stall_now) begin
        done = 1'b1;
        break;
      end
      stalls++;
      chk("bubble_validw", {31'h0, ValidW}, 32'h0);
    end
    dmem_rsp_valid = 1'b0;
    if (!done) chk("timeout", 32'h0, 32'h1);
    chk("stall_cycles", stalls, exp_stalls);
    chk("ValidW", {31'h0, ValidW}, 32'h1);
    chk("RegWriteW", {31'h0, RegWriteW}, {31'h0, regw && !mis});
    chk("MisalignM", {31'h0, MisalignM}, {31'h0, mis});
    chk("RdW", {27'h0, RdW}, {27'h0, rd_idx});
    chk("ALUResultW", ALUResultW, addr);
    chk("PCPlus4W", PCPlus4W, pc4);
    if (is_load) chk("ReadDataW", ReadDataW, model_load(f3, addr, rdata));
    if (!rd && !wr) chk("ReadDataW_alu", ReadDataW, 32'h0);
    last_alu = addr;
  endtask

  // One empty slot: no request, no stall, bubble into W with data held.
  task automatic idle_cycle();
    ValidM = 1'b0; dmem_rsp_valid = 1'b0;
    #1;
    chk("idle_stall", {31'h0, StallM}, 32'h0);
    chk("idle_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    tick();
    chk("idle_validw", {31'h0, ValidW}, 32'h0);
    chk("idle_regwritew", {31'h0, RegWriteW}, 32'h0);
    chk("idle_misalign", {31'h0, MisalignM}, 32'h0);
    chk("idle_alu_hold", ALUResultW, last_alu);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [12];
  logic [2:0] ld_f3 [5];
  logic [31:0] cw;
  logic [3:0]  cb;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, 32'h0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 32'h0000_0080, 32'h0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 32'h0, 4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 32'h0000_8001, 32'h0, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0000_007F, 32'h0000_007F, 32'h0, 4'b0000};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234_F000, 32'hFFFF_F000, 32'h0, 4'b0000};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h1122_3344, 32'h0000_0022, 32'h0, 4'b0000};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 32'h0, 32'h7878_7878, 4'b0010};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'hAABB_CCDD, 32'h0, 32'h0, 32'hCCDD_CCDD, 4'b1100};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h204, 32'h0102_0304, 32'h0, 32'h0, 32'h0102_0304, 4'b1111};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00EE, 32'h0, 32'h0, 32'hEEEE_EEEE, 4'b1000};
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    reset_n = 1'b0; ValidM = 1'b0; RegWriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    Funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0; RdM = 5'd0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
    #3;
    chk("rst_ValidW", {31'h0, ValidW}, 32'h0);
    chk("rst_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    chk("rst_RdW", {27'h0, RdW}, 32'h0);
    chk("rst_ALUResultW", ALUResultW, 32'h0);
    chk("rst_ReadDataW", ReadDataW, 32'h0);
    chk("rst_PCPlus4W", PCPlus4W, 32'h0);
    chk("rst_MisalignM", {31'h0, MisalignM}, 32'h0);
    chk("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("rst_req_be", {28'h0, dmem_req_be}, 32'h0);
    chk("rst_StallM", {31'h0, StallM}, 32'h0);
    tick();
    reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      do_instr(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               vecs[i].rdata, 5'd3, vecs[i].rd, 0, 1, 1'b0, cw, cb);
      chk("vec_be", {28'h0, cb}, {28'h0, vecs[i].exp_be});
      if (vecs[i].wr) chk("vec_wdata", cw, vecs[i].exp_wdata);
      else chk("vec_rdata", ReadDataW, vecs[i].exp_data);
    end

    // LW with a 3-cycle response.
    do_instr(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 0, 3, 1'b0, cw, cb);
    chk("lw_readdata", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_regwrite", {31'h0, RegWriteW}, 32'h1);
    // SB held off by ready for 2 cycles.
    do_instr(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 2, 1, 1'b0, cw, cb);
    chk("sb_wdata", cw, 32'h7878_7878);
    idle_cycle();
    // Misaligned SH: flag for exactly one cycle.
    do_instr(1'b0, 1'b1, 3'b001, 32'h301, 32'h5555, 32'h0, 5'd0, 1'b0, 0, 1, 1'b0, cw, cb);
    idle_cycle();
    // Back-to-back ALU ops.
    do_instr(1'b0, 1'b0, 3'b000, 32'hA, 32'h0, 32'h0, 5'd5, 1'b1, 0, 1, 1'b0, cw, cb);
    do_instr(1'b0, 1'b0, 3'b000, 32'hB, 32'h0, 32'h0, 5'd5, 1'b1, 0, 1, 1'b1, cw, cb);
    idle_cycle();

    // Reset while a load is outstanding; a late response must be ignored.
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1; Funct3M = 3'b010;
    ALUResultM = 32'h400; RdM = 5'd9; PCPlus4M = 32'h44; dmem_req_ready = 1'b1;
    tick();
    #1;
    chk("wr_stall", {31'h0, StallM}, 32'h1);
    chk("wr_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    ValidM = 1'b0; reset_n = 1'b0;
    #1;
    chk("wr_rst_ValidW", {31'h0, ValidW}, 32'h0);
    chk("wr_rst_ALUResultW", ALUResultW, 32'h0);
    chk("wr_rst_ReadDataW", ReadDataW, 32'h0);
    chk("wr_rst_RdW", {27'h0, RdW}, 32'h0);
    chk("wr_rst_PCPlus4W", PCPlus4W, 32'h0);
    chk("wr_rst_stall", {31'h0, StallM}, 32'h0);
    tick();
    reset_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1234_5678;
    #1;
    chk("late_rsp_stall", {31'h0, StallM}, 32'h0);
    tick();
    chk("late_rsp_validw", {31'h0, ValidW}, 32'h0);
    chk("late_rsp_readdata", ReadDataW, 32'h0);
    dmem_rsp_valid = 1'b0;
    last_alu = 32'h0;

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(2, 0);
      if (kind == 1) f3 = ld_f3[$urandom_range(4, 0)];
      else if (kind == 2) f3 = ld_f3[$urandom_range(2, 0)];
      else f3 = 3'($urandom);
      do_instr(kind == 1, kind == 2, f3, $urandom, $urandom, $urandom, 5'($urandom),
               (kind == 2) ? 1'b0 : 1'($urandom), $urandom_range(3, 0), $urandom_range(4, 1),
               1'($urandom), cw, cb);
      if ($urandom_range(3, 0) == 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs (ALUResultM, WriteDataM, PCPlus4M, RdM) plus MEM-stage control.
- Issues load/store requests to the data memory over a valid/ready request channel and a valid-only response channel.
- Aligns and sign-extends load data and produces the registered MEM/WB outputs.
- Raises StallM while a memory access is outstanding, so upstream pipeline registers hold.

Parameters:
- XLEN, 32, datapath and address width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ValidM  in  1  EX/MEM slot holds a real instruction.
- RegWriteM  in  1  instruction writes Rd.
- MemReadM  in  1  load.
- MemWriteM  in  1  store. MemReadM and MemWriteM are never both 1.
- Funct3M  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010 only.
- ALUResultM  in  XLEN  effective address, or ALU result for non-memory instructions.
- WriteDataM  in  XLEN  store data.
- PCPlus4M  in  XLEN  link value.
- RdM  in  REG_AW  destination register.
- dmem_req_valid  out  1  request present.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  XLEN  word-aligned address: ALUResultM with [1:0] forced to 00.
- dmem_req_wdata  out  XLEN  lane-replicated store data.
- dmem_req_be  out  4  byte enables. All 0 for loads.
- dmem_rsp_valid  in  1  load data returned.
- dmem_rsp_rdata  in  XLEN  raw load word.
- StallM  out  1  combinational; hold EX/MEM and earlier stages.
- MisalignM  out  1  registered, 1-cycle misaligned-access flag.
- ValidW, RegWriteW  out  1 each  MEM/WB valid and write enable.
- RdW  out  REG_AW  MEM/WB destination register.
- ALUResultW, ReadDataW, PCPlus4W  out  XLEN each  MEM/WB data.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE. All registered outputs are 0: ValidW, RegWriteW, RdW, ALUResultW, ReadDataW, PCPlus4W, MisalignM. The request interface outputs are 0 in IDLE with ValidM=0.
- FSM states: IDLE, WAIT_RSP.
- Misalignment: misaligned when H/HU with addr[0]=1, or W with addr[1:0]!=00.
- memop = ValidM & (MemReadM | MemWriteM) & !misaligned.
- IDLE, dmem_req_valid: equals memop. Request fields are driven combinationally from the M inputs.
- IDLE, store accepted (memop & MemWriteM & ready): complete this cycle, no stall, W registers capture the instruction. Stores never wait for a response.
- IDLE, load accepted (memop & MemReadM & ready): go to WAIT_RSP, StallM=1.
- IDLE, memop & !ready: StallM=1 and stay in IDLE. Inputs are held stable by upstream, so the request repeats until accepted.
- WAIT_RSP: dmem_req_valid=0. StallM = !dmem_rsp_valid. On rsp_valid, capture aligned data and the M fields into the W registers, then go to IDLE.
- dmem_rsp_valid is ignored in IDLE.
- Load alignment: take byte lane addr[1:0] or halfword lane addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Store lanes: SB wdata={4{WriteDataM[7:0]}}, be=0001<<addr[1:0]. SH wdata={2{WriteDataM[15:0]}}, be=0011<<{addr[1],0}. SW wdata=WriteDataM, be=1111.
- Non-memory instruction (ValidM & !MemRead & !MemWrite): registered pass-through, 1-cycle latency. ReadDataW=0.
- Misaligned access: no request and no stall. Next cycle MisalignM=1, ValidW=1, RegWriteW=0.
- Bubble: any cycle with StallM=1 or ValidM=0 loads W with ValidW=0, RegWriteW=0. Data fields hold their previous values.
- Reset during WAIT_RSP: the outstanding load is abandoned. A response arriving after reset is ignored.

Decomposition:
- Shared package (rvx_mem_pkg): Funct3 size encodings as constants, and the state enum typedef {IDLE, WAIT_RSP}.
- One sub-module, load_align: combinational; takes rdata, addr[1:0] and funct3, returns the extended XLEN value. Bench-reusable.

Test Plan:
- LW at addr 0x100, ready=1, response after 3 cycles with rdata 0xDEADBEEF -> req_addr=0x100, be=0000; StallM high for exactly 3 cycles; then ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB at addr 0x103, rdata 0x80FF_0000 -> ReadDataW=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 with rdata 0x8001_0000 -> 0xFFFF8001.
- SB at 0x201, WriteDataM=0x12345678, ready low for 2 cycles -> StallM=1 for 2 cycles; on acceptance wdata=0x78787878, be=0010, we=1, addr=0x200; no WAIT_RSP entered.
- SH at 0x301 -> no request issued; next cycle MisalignM=1, ValidW=1, RegWriteW=0; MisalignM low the following cycle.
- Back-to-back ALU ops with RdM=5, ALUResult 0xA then 0xB -> ALUResultW 0xA then 0xB on consecutive cycles, StallM=0 throughout.
- LW accepted, reset_n pulsed low in WAIT_RSP, then rsp_valid arrives -> all W outputs 0, state IDLE, response ignored (ValidW stays 0).
